// File: rtl/shifter_pkg.sv
// shifter_pkg: mode codes, FSM state encoding and mode helper for seq_shifter.
// Rev 1.0
`default_nettype none

package shifter_pkg;

  localparam logic [2:0] SH_PASS = 3'b000;
  localparam logic [2:0] SH_LSL  = 3'b001;
  localparam logic [2:0] SH_LSR  = 3'b010;
  localparam logic [2:0] SH_ASR  = 3'b011;
  localparam logic [2:0] SH_ROL  = 3'b100;
  localparam logic [2:0] SH_ROR  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Pass and the two reserved codes leave the operand untouched.
  function automatic logic mode_moves(input logic [2:0] m);
    case (m)
      SH_LSL, SH_LSR, SH_ASR, SH_ROL, SH_ROR: mode_moves = 1'b1;
      default:                                mode_moves = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// shift_step: combinational k-bit shift/rotate, built as k chained 1-bit moves.
// Rev 1.0
`default_nettype none

module shift_step
  import shifter_pkg::*;
#(
  parameter int W    = 16,
  parameter int STEP = 1,
  localparam int KW  = $clog2(STEP + 1)
) (
  input  logic [W-1:0]  value,
  input  logic [2:0]    mode,
  input  logic [KW-1:0] k,
  output logic [W-1:0]  next_value,
  output logic          bit_out
);

  logic [W-1:0] v;
  logic         b;

  // Chaining single-bit moves keeps cout identical to a 1-bit-per-clock run.
  always_comb begin
    v = value;
    b = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (KW'(i) < k) begin
        case (mode)
          SH_LSL: begin b = v[W-1]; v = {v[W-2:0], 1'b0};   end
          SH_LSR: begin b = v[0];   v = {1'b0, v[W-1:1]};   end
          SH_ASR: begin b = v[0];   v = {v[W-1], v[W-1:1]}; end
          SH_ROL: begin b = v[W-1]; v = {v[W-2:0], v[W-1]}; end
          SH_ROR: begin b = v[0];   v = {v[0], v[W-1:1]};   end
          default: ;
        endcase
      end
    end
    next_value = v;
    bit_out    = b;
  end

endmodule

`default_nettype wire

// File: rtl/seq_shifter.sv
// seq_shifter: iterative shifter/rotator, STEP bits per clock, start/busy/done handshake.
// Rev 1.0
`default_nettype none

module seq_shifter
  import shifter_pkg::*;
#(
  parameter int W    = 16,
  parameter int STEP = 1,
  localparam int AW  = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  in,
  input  logic [2:0]    shift,
  input  logic [AW-1:0] amt,
  output logic [W-1:0]  sout,
  output logic          cout,
  output logic          busy,
  output logic          done
);

  localparam int KW = $clog2(STEP + 1);

  state_t        state;
  state_t        state_next;
  logic [2:0]    mode;
  logic [AW-1:0] rem;
  logic [AW-1:0] rem_left;
  logic [KW-1:0] k;
  logic [W-1:0]  step_value;
  logic          step_bit;

  always_comb begin
    k        = (rem > AW'(STEP)) ? KW'(STEP) : KW'(rem);
    rem_left = rem - AW'(k);
  end

  shift_step #(
    .W    (W),
    .STEP (STEP)
  ) u_step (
    .value      (sout),
    .mode       (mode),
    .k          (k),
    .next_value (step_value),
    .bit_out    (step_bit)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start)
          state_next = (amt == '0 || !mode_moves(shift)) ? S_DONE : S_SHIFT;
        else
          state_next = S_IDLE;
      end
      S_SHIFT: begin
        if (rem_left == '0)
          state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      sout  <= '0;
      cout  <= 1'b0;
      mode  <= SH_PASS;
      rem   <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            sout <= in;
            mode <= shift;
            rem  <= amt;
            cout <= 1'b0;
          end
        end
        S_SHIFT: begin
          sout <= step_value;
          cout <= step_bit;
          rem  <= rem_left;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

endmodule

`default_nettype wire
